// File: rtl/pri_encoder_rr.sv
// rtl/pri_encoder_rr.sv - registered N-way priority encoder with fixed/round-robin selection and valid/ready output
module pri_encoder_rr #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rr_en,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [W:0]   pend_cnt
);

    logic [N-1:0] pending_q, pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [N-1:0] out_onehot_q, out_onehot_d;
    logic [W-1:0] last_q, last_d;
    logic [W:0]   pend_cnt_q, pend_cnt_d;

    logic         load;
    logic [W-1:0] start;
    logic [N-1:0] rot;
    logic [W-1:0] ofs;
    logic [W:0]   sum;
    logic [W-1:0] sel;
    logic [N-1:0] sel_onehot;

    // Rotate pending so the search origin sits at bit 0, then find the lowest set bit.
    always_comb begin
        start = '0;
        if (rr_en) begin
            start = (last_q == W'(N - 1)) ? '0 : last_q + 1'b1;
        end
        rot = (pending_q >> start) | (pending_q << (N - int'(start)));
        ofs = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                ofs = W'(j);
            end
        end
        sum = {1'b0, start} + {1'b0, ofs};
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        sel        = sum[W-1:0];
        sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel;
    end

    always_comb begin
        load         = !out_valid_q || out_ready;
        pending_d    = pending_q | req;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        last_d       = last_q;
        if (load) begin
            if (|pending_q) begin
                out_valid_d  = 1'b1;
                out_idx_d    = sel;
                out_onehot_d = sel_onehot;
                last_d       = sel;
                pending_d    = (pending_q & ~sel_onehot) | req;
            end else begin
                out_valid_d = 1'b0;
                pending_d   = req;
            end
        end
        pend_cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            pend_cnt_d = pend_cnt_d + {{W{1'b0}}, pending_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            last_q       <= W'(N - 1);
            pend_cnt_q   <= '0;
        end else begin
            pending_q    <= pending_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            last_q       <= last_d;
            pend_cnt_q   <= pend_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign pend_cnt   = pend_cnt_q;

endmodule

// File: tb/tb_pri_encoder_rr.sv
// tb/tb_pri_encoder_rr.sv - directed-vector bench for pri_encoder_rr at N=8 and N=5
module tb_pri_encoder_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req8;
    logic       rr8, rdy8, v8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic [3:0] cnt8;
    logic [4:0] req5;
    logic       rr5, rdy5, v5;
    logic [2:0] idx5;
    logic [4:0] oh5;
    logic [3:0] cnt5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pri_encoder_rr #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .rr_en(rr8), .out_ready(rdy8),
        .out_valid(v8), .out_idx(idx8), .out_onehot(oh8), .pend_cnt(cnt8)
    );

    pri_encoder_rr #(.N(5)) u5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .rr_en(rr5), .out_ready(rdy5),
        .out_valid(v5), .out_idx(idx5), .out_onehot(oh5), .pend_cnt(cnt5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic v, input logic [2:0] idx,
                        input logic [7:0] oh, input logic [3:0] cnt);
        chk({tag, "_valid"}, 32'(v8), 32'(v));
        if (v) begin
            chk({tag, "_idx"}, 32'(idx8), 32'(idx));
            chk({tag, "_onehot"}, 32'(oh8), 32'(oh));
        end
        chk({tag, "_cnt"}, 32'(cnt8), 32'(cnt));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req8 = '0; rr8 = 1'b0; rdy8 = 1'b1;
        req5 = '0; rr5 = 1'b1; rdy5 = 1'b1;
        tick; tick;
        chk("rst_valid", 32'(v8), 0);
        chk("rst_idx", 32'(idx8), 0);
        chk("rst_onehot", 32'(oh8), 0);
        chk("rst_cnt", 32'(cnt8), 0);
        rst_n = 1'b1;
        tick;

        // single pulse on bit 5
        req8 = 8'h20;
        tick; chk8("pulse_t1", 1'b0, 3'd0, 8'h00, 4'd1);
        req8 = 8'h00;
        tick; chk8("pulse_t2", 1'b1, 3'd5, 8'h20, 4'd0);
        tick; chk8("pulse_t3", 1'b0, 3'd0, 8'h00, 4'd0);

        // fixed priority, two requests in one pulse
        req8 = 8'h81;
        tick; chk8("fix_t1", 1'b0, 3'd0, 8'h00, 4'd2);
        req8 = 8'h00;
        tick; chk8("fix_t2", 1'b1, 3'd0, 8'h01, 4'd1);
        tick; chk8("fix_t3", 1'b1, 3'd7, 8'h80, 4'd0);
        tick; chk8("fix_t4", 1'b0, 3'd0, 8'h00, 4'd0);

        // round-robin with all lines held; last is 7 so the search starts at 0
        rr8 = 1'b1; req8 = 8'hFF;
        tick; chk8("rr_fill", 1'b0, 3'd0, 8'h00, 4'd8);
        for (int k = 0; k < 10; k++) begin
            tick;
            chk8($sformatf("rr_seq%0d", k), 1'b1, 3'(k % 8), 8'(1 << (k % 8)), 4'd8);
        end

        // asynchronous reset mid-operation with requests still driven
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(v8), 0);
        chk("arst_idx", 32'(idx8), 0);
        chk("arst_onehot", 32'(oh8), 0);
        chk("arst_cnt", 32'(cnt8), 0);
        req8 = 8'h00;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk8($sformatf("post_rst%0d", k), 1'b0, 3'd0, 8'h00, 4'd0);
        end

        // fixed priority with all lines held keeps granting index 0
        rr8 = 1'b0; req8 = 8'hFF;
        tick; chk8("fixall_fill", 1'b0, 3'd0, 8'h00, 4'd8);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk8($sformatf("fixall%0d", k), 1'b1, 3'd0, 8'h01, 4'd8);
        end
        #2 rst_n = 1'b0;
        req8 = 8'h00;
        @(negedge clk) rst_n = 1'b1;
        tick;

        // backpressure: index 3 held while 2 and 3 are requested again
        req8 = 8'h08;
        tick; chk8("bp_fill", 1'b0, 3'd0, 8'h00, 4'd1);
        req8 = 8'h00; rdy8 = 1'b0;
        tick; chk8("bp_present", 1'b1, 3'd3, 8'h08, 4'd0);
        req8 = 8'h0C;
        tick; chk8("bp_stall1", 1'b1, 3'd3, 8'h08, 4'd2);
        req8 = 8'h00;
        tick; chk8("bp_stall2", 1'b1, 3'd3, 8'h08, 4'd2);
        rdy8 = 1'b1;
        tick; chk8("bp_go1", 1'b1, 3'd2, 8'h04, 4'd1);
        tick; chk8("bp_go2", 1'b1, 3'd3, 8'h08, 4'd0);
        tick; chk8("bp_idle", 1'b0, 3'd0, 8'h00, 4'd0);

        // N=5 round-robin wraps from index 4 back to 0
        req5 = 5'h11;
        tick;
        chk("n5_fill_valid", 32'(v5), 0);
        chk("n5_fill_cnt", 32'(cnt5), 2);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("n5_valid%0d", k), 32'(v5), 1);
            chk($sformatf("n5_idx%0d", k), 32'(idx5), (k % 2 == 0) ? 0 : 4);
            chk($sformatf("n5_onehot%0d", k), 32'(oh5), (k % 2 == 0) ? 32'h01 : 32'h10);
            chk($sformatf("n5_range%0d", k), 32'(idx5 <= 3'd4), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pri_encoder_rr.md
# pri_encoder_rr

Parametrised, registered successor to the combinational 8-to-3 one-hot encoder. It accepts an N-bit request vector, latches requests into a sticky pending register, and issues one granted index at a time through a valid/ready output handshake. Priority is selectable at run time: fixed (lowest index wins) or round-robin. It sits between request sources (interrupt lines, channel flags) and a single consumer that services one index per transfer.

## Interface
- N, default 8: number of request lines; any value ≥ 2, power of two not required.
- W, default $clog2(N): index width, derived from N, not overridden.
- clk  input  1: single clock, rising edge.
- rst_n  input  1: asynchronous active-low reset.
- req  input  N: request pulses or levels; bit i requests index i.
- rr_en  input  1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- out_ready  input  1: consumer accepts the presented index.
- out_valid  output  1: out_idx/out_onehot hold a valid grant.
- out_idx  output  W: granted index, binary.
- out_onehot  output  N: granted index, one-hot (1 << out_idx).
- pend_cnt  output  W+1: popcount of the pending register.

## Operation
- Registers: pending[N-1:0], the output stage (out_valid, out_idx, out_onehot), last[W-1:0] (last selected index), and pend_cnt.
- load = !out_valid | out_ready, evaluated each cycle.
- If load and pending != 0:
  - select index s from pending.
  - out_idx <= s, out_onehot <= 1<<s, out_valid <= 1, last <= s.
  - pending <= (pending & ~(1<<s)) | req.
- If load and pending == 0: out_valid <= 0; pending <= req. out_idx and out_onehot keep their previous values but are don't-care.
- If !load (stall): pending <= pending | req; the output stage holds every bit stable.
- Selection:
  - rr_en=0: lowest set index of pending.
  - rr_en=1: first set bit searching upward from (last+1) mod N, wrapping at N-1 → 0.
- Because the presented bit is cleared from pending, a req on that same bit while it is presented is recorded as a new request.
- Multiple req cycles on an already-pending bit merge into one request; no count is kept per line.
- last updates in both modes. A change of rr_en affects the next selection only.
- pend_cnt is registered and equals popcount(pending) after every edge.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_idx=0, out_onehot=0, pend_cnt=0.
  - pending=0, last=N-1, so the first round-robin search starts at 0.
- Reset mid-operation discards all pending requests and any presented grant immediately, with no clock required. The first selection after reset release behaves as it does from power-up.
- Latency: req bit set in cycle t appears in pending after edge t+1, then as out_valid after edge t+2, provided the output stage can load.
- Throughput: one grant per cycle while out_ready=1 and pending != 0.
- Handshake:
  - A transfer occurs on an edge with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_idx and out_onehot must not change.
  - out_valid never drops without a transfer, except on reset.
- Boundaries:
  - All N bits pending: pend_cnt=N.
  - Index N-1 wraps to 0 in round-robin.
  - req=0 with pending=0: the output goes invalid after the current transfer.

## Test plan
- Reset: drive rst_n=0 mid-simulation with req=0xFF → out_valid=0, out_idx=0, out_onehot=0x00, pend_cnt=0 immediately. After release with req=0, there are no grants.
- Single pulse (N=8, rr_en=0, out_ready=1): req=0x20 for one cycle at t → out_valid=1, out_idx=5, out_onehot=0x20 in cycle t+2 only; pend_cnt goes 1 → 0.
- Fixed priority: req=0x81 for one cycle, out_ready=1 → idx 0 then idx 7 on consecutive cycles, then out_valid=0.
- Mode contrast, req=0xFF held and out_ready=1:
  - rr_en=0 → idx 0 every cycle.
  - rr_en=1 → idx sequence 0,1,2,…,7,0,1, with no repeats before wrap.
- Backpressure (rr_en=0): idx 3 is presented with out_ready=0 while req=0x0C is pulsed → out_idx=3 and out_onehot=0x08 stay stable, pend_cnt=2. Raise out_ready → idx 2, then idx 3, then out_valid=0.
- Non-power-of-two N=5, rr_en=1, req=0x11 held → idx alternates 0,4,0,4. out_idx never exceeds 4.
